pbit_sweep_controller: RTL and testbench

- Time-multiplexed driver for a single shared P-bit: for each network node i it computes the weighted input I_i = h_i + sum over j≠i of J_ij·s_j, where s_j = +1 if m_state[j]=1 and −1 if it is 0.
- It saturates I_i to signed 8 bits, pulses enable, and captures the P-bit's m_i back into the node state vector.
- It sits between the weight/bias memory and the P-bit. One start runs one sequential (Gibbs-order) sweep over all N nodes.

---
 rtl/pbit_sweep_controller.sv | 163 ++++++++++++++++
 tb/tb_pbit_sweep_controller.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pbit_sweep_controller.sv
// pbit_sweep_controller: time-multiplexes one shared P-bit over N network nodes.
// For each node it accumulates h_i + sum(J_ij * s_j), saturates the sum to
// signed 8 bits, strobes the P-bit and writes its answer back into m_state.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   start, load_init      begin one Gibbs sweep; optionally load init_state
//   init_state            initial node states (bit j = node j)
//   w_row, w_col          weight/bias memory address (row = current node)
//   w_data                J[w_row][w_col], one cycle after the address
//   h_data                bias h[w_row], combinational
//   I_i, enable           saturated weighted input and P-bit update strobe
//   m_i                   P-bit output, captured at the end of the strobe
//   m_state               current node states
//   busy, sweep_done      sweep in progress / one-cycle end-of-sweep pulse
module pbit_sweep_controller #(
    parameter int N         = 4,
    parameter int ACC_WIDTH = 16,
    localparam int RW       = $clog2(N),
    localparam int CW       = $clog2(N + 1)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 load_init,
    input  logic [N-1:0]         init_state,
    output logic [RW-1:0]        w_row,
    output logic [RW-1:0]        w_col,
    input  logic signed [7:0]    w_data,
    input  logic signed [7:0]    h_data,
    output logic signed [7:0]    I_i,
    output logic                 enable,
    input  logic                 m_i,
    output logic [N-1:0]         m_state,
    output logic                 busy,
    output logic                 sweep_done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACC,
        S_DRIVE
    } state_t;

    localparam logic signed [ACC_WIDTH-1:0] SAT_HI = ACC_WIDTH'(127);
    localparam logic signed [ACC_WIDTH-1:0] SAT_LO = ACC_WIDTH'(-128);

    state_t                       r_state;
    state_t                       w_next;
    logic [RW-1:0]                r_row;
    logic [CW-1:0]                r_cnt;
    logic signed [ACC_WIDTH-1:0]  r_acc;
    logic signed [7:0]            r_ii;
    logic [N-1:0]                 r_m;
    logic                         r_done;

    logic                         w_last_col;
    logic                         w_last_row;
    logic [RW-1:0]                w_k;
    logic signed [ACC_WIDTH-1:0]  w_h_ext;
    logic signed [ACC_WIDTH-1:0]  w_j_ext;
    logic signed [ACC_WIDTH-1:0]  w_term;
    logic signed [ACC_WIDTH-1:0]  w_sum;
    logic signed [7:0]            w_sat;

    assign w_last_col = (r_cnt == CW'(N));
    assign w_last_row = (r_row == RW'(N - 1));
    // Column whose weight is on w_data now (address was issued last cycle).
    assign w_k        = RW'(r_cnt - CW'(1));
    assign w_h_ext    = {{(ACC_WIDTH-8){h_data[7]}}, h_data};
    assign w_j_ext    = {{(ACC_WIDTH-8){w_data[7]}}, w_data};

    // Negating after widening keeps -(-128) = +128 exact.
    always_comb begin
        w_term = '0;
        if (w_k != r_row) begin
            w_term = r_m[w_k] ? w_j_ext : -w_j_ext;
        end
    end

    assign w_sum = r_acc + w_term;

    always_comb begin
        w_sat = w_sum[7:0];
        if (w_sum > SAT_HI) begin
            w_sat = 8'sh7F;
        end else if (w_sum < SAT_LO) begin
            w_sat = 8'sh80;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (start) w_next = S_ACC;
            S_ACC:   if (w_last_col) w_next = S_DRIVE;
            S_DRIVE: w_next = w_last_row ? S_IDLE : S_ACC;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_row  <= '0;
            r_cnt  <= '0;
            r_acc  <= '0;
            r_ii   <= '0;
            r_m    <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (load_init) begin
                            r_m <= init_state;
                        end
                        r_row <= '0;
                        r_cnt <= '0;
                    end
                end
                S_ACC: begin
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == '0) begin
                        r_acc <= w_h_ext;
                    end else begin
                        r_acc <= w_sum;
                    end
                    if (w_last_col) begin
                        r_ii <= w_sat;
                    end
                end
                S_DRIVE: begin
                    r_m[r_row] <= m_i;
                    r_cnt      <= '0;
                    if (w_last_row) begin
                        r_done <= 1'b1;
                    end else begin
                        r_row <= r_row + RW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign w_row      = r_row;
    assign w_col      = (r_state == S_ACC && !w_last_col) ? RW'(r_cnt) : '0;
    assign I_i        = r_ii;
    assign enable     = (r_state == S_DRIVE);
    assign m_state    = r_m;
    assign busy       = (r_state != S_IDLE);
    assign sweep_done = r_done;

endmodule

// File: tb/tb_pbit_sweep_controller.sv
// tb_pbit_sweep_controller: self-checking bench for pbit_sweep_controller
// with a weight/bias memory model and a queue of expected I_i values.
module tb_pbit_sweep_controller;

    localparam int N  = 4;
    localparam int RW = $clog2(N);

    logic                clk = 1'b0;
    logic                reset_n = 1'b0;
    logic                start = 1'b0;
    logic                load_init = 1'b0;
    logic [N-1:0]        init_state = '0;
    logic [RW-1:0]       w_row;
    logic [RW-1:0]       w_col;
    logic signed [7:0]   w_data = '0;
    logic signed [7:0]   h_data;
    logic signed [7:0]   I_i;
    logic                enable;
    logic                m_i = 1'b0;
    logic [N-1:0]        m_state;
    logic                busy;
    logic                sweep_done;

    pbit_sweep_controller #(.N(N), .ACC_WIDTH(16)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .load_init  (load_init),
        .init_state (init_state),
        .w_row      (w_row),
        .w_col      (w_col),
        .w_data     (w_data),
        .h_data     (h_data),
        .I_i        (I_i),
        .enable     (enable),
        .m_i        (m_i),
        .m_state    (m_state),
        .busy       (busy),
        .sweep_done (sweep_done)
    );

    always #5 clk = ~clk;

    logic signed [7:0] J [N][N];
    logic signed [7:0] h [N];

    always @(posedge clk) w_data <= J[w_row][w_col];
    assign h_data = h[w_row];

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    int t0 = 0;
    int last_en = -1;
    int en_cnt = 0;
    int dut_ii [N];
    int exp_q [$];
    logic [N-1:0] exp_state = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (reset_n && enable) begin
            en_cnt++;
            if (last_en >= 0) chk("enable_spacing", cyc - last_en, N + 2);
            else chk("first_enable_latency", cyc - t0, N + 1);
            last_en = cyc;
            dut_ii[w_row] = int'(I_i);
            if (exp_q.size() == 0) chk("unexpected_enable", 1, 0);
            else chk("I_i", int'(I_i), exp_q.pop_front());
        end
    end

    function automatic int clamp8(input int a);
        if (a > 127) return 127;
        if (a < -128) return -128;
        return a;
    endfunction

    // Gibbs-order reference: each row sees the states written by earlier rows.
    task automatic model_push(input bit ld, input logic [N-1:0] init, input bit mi);
        logic [N-1:0] st;
        int acc;
        st = ld ? init : exp_state;
        for (int i = 0; i < N; i++) begin
            acc = int'(h[i]);
            for (int j = 0; j < N; j++) begin
                if (j != i) acc += st[j] ? int'(J[i][j]) : -int'(J[i][j]);
            end
            exp_q.push_back(clamp8(acc));
            st[i] = mi;
        end
        exp_state = st;
    endtask

    task automatic set_uniform(input int hv, input int jv);
        for (int i = 0; i < N; i++) begin
            h[i] = 8'(hv);
            for (int j = 0; j < N; j++) J[i][j] = 8'(jv);
        end
    endtask

    task automatic start_sweep(input bit ld, input logic [N-1:0] init, input bit mi);
        model_push(ld, init, mi);
        m_i = mi;
        load_init = ld;
        init_state = init;
        en_cnt = 0;
        last_en = -1;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        t0 = cyc + 1;
        #1;
        start = 1'b0;
        load_init = 1'b0;
    endtask

    task automatic run_sweep(input bit ld, input logic [N-1:0] init,
                             input bit mi, input bit mid);
        bit done;
        start_sweep(ld, init, mi);
        @(negedge clk);
        chk("busy_after_start", int'(busy), 1);
        done = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            start = mid && (c == 8);
            if (sweep_done) begin
                done = 1;
                break;
            end
        end
        start = 1'b0;
        chk("sweep_done_seen", int'(done), 1);
        chk("sweep_done_latency", cyc - t0, N * (N + 2));
        chk("busy_at_done", int'(busy), 0);
        chk("enable_count", en_cnt, N);
        chk("m_state_final", int'(m_state), int'(exp_state));
        chk("queue_drained", exp_q.size(), 0);
        @(negedge clk);
        chk("sweep_done_one_cycle", int'(sweep_done), 0);
        exp_q.delete();
    endtask

    typedef struct {
        int           hv;
        int           jv;
        logic [N-1:0] init;
        bit           ld;
        bit           mi;
        bit           mid;
        int           row0;
        logic [N-1:0] fin;
    } vec_t;

    vec_t vecs [5];

    initial begin
        bit seen;
        vecs[0] = '{hv: 5,    jv: 0,    init: 4'b0000, ld: 0, mi: 1, mid: 1, row0: 5,    fin: 4'b1111};
        vecs[1] = '{hv: 0,    jv: 10,   init: 4'b0101, ld: 1, mi: 0, mid: 0, row0: -10,  fin: 4'b0000};
        vecs[2] = '{hv: 127,  jv: 127,  init: 4'b1111, ld: 1, mi: 1, mid: 0, row0: 127,  fin: 4'b1111};
        vecs[3] = '{hv: 0,    jv: -128, init: 4'b0000, ld: 1, mi: 0, mid: 0, row0: 127,  fin: 4'b0000};
        vecs[4] = '{hv: -128, jv: 127,  init: 4'b0000, ld: 1, mi: 0, mid: 0, row0: -128, fin: 4'b0000};
        set_uniform(0, 0);

        reset_n = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            start = 1'($urandom_range(0, 1));
            m_i = 1'($urandom_range(0, 1));
            load_init = 1'($urandom_range(0, 1));
            init_state = N'($urandom);
        end
        #1;
        chk("rst_I_i", int'(I_i), 0);
        chk("rst_enable", int'(enable), 0);
        chk("rst_m_state", int'(m_state), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_sweep_done", int'(sweep_done), 0);
        chk("rst_w_row", int'(w_row), 0);
        chk("rst_w_col", int'(w_col), 0);
        @(negedge clk);
        start = 1'b0;
        load_init = 1'b0;
        reset_n = 1'b1;

        for (int v = 0; v < 5; v++) begin
            set_uniform(vecs[v].hv, vecs[v].jv);
            run_sweep(vecs[v].ld, vecs[v].init, vecs[v].mi, vecs[v].mid);
            chk("table_row0_I_i", dut_ii[0], vecs[v].row0);
            chk("table_m_state", int'(m_state), int'(vecs[v].fin));
        end

        set_uniform(7, 9);
        start_sweep(1'b1, 4'b1010, 1'b1);
        seen = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (enable && w_row == 2) begin
                seen = 1;
                break;
            end
        end
        chk("abort_reached_row2", int'(seen), 1);
        reset_n = 1'b0;
        #1;
        chk("abort_enable", int'(enable), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_m_state", int'(m_state), 0);
        chk("abort_I_i", int'(I_i), 0);
        exp_q.delete();
        exp_state = '0;
        seen = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (c == 2) reset_n = 1'b1;
            if (sweep_done || busy) seen = 1;
        end
        chk("abort_no_done", int'(seen), 0);

        set_uniform(0, 0);
        J[1][0] = 8'sd20;
        run_sweep(1'b1, 4'b0000, 1'b1, 1'b0);
        chk("seq_row0_I_i", dut_ii[0], 0);
        chk("seq_row1_I_i", dut_ii[1], 20);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
